// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops narrow FIFO words and packs RATIO of them
// into one wide valid/ready beat; flush closes a partial beat as last.
module fifo_rd_packer #(
   parameter int DSIZE = 8,
   parameter int RATIO = 4
) (
   input  logic                     rclk,
   input  logic                     rrst_n,
   input  logic [DSIZE-1:0]         rdata,
   input  logic                     rempty,
   output logic                     rinc,
   input  logic                     flush,
   output logic [DSIZE*RATIO-1:0]   m_data,
   output logic [RATIO-1:0]         m_keep,
   output logic                     m_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     flush_done
);

   localparam int LW = $clog2(RATIO);
   localparam int CW = LW + 1;
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t FULL = cnt_t'(RATIO);

   logic [RATIO-1:0][DSIZE-1:0] acc_q, acc_d;
   logic [RATIO-1:0][DSIZE-1:0] m_data_q, m_data_d;
   cnt_t                        cnt_q, cnt_d;
   logic [RATIO-1:0]            m_keep_q, m_keep_d;
   logic                        m_last_q, m_last_d;
   logic                        m_valid_q, m_valid_d;
   logic                        flush_pend_q, flush_pend_d;
   logic                        flush_done_q, flush_done_d;
   logic                        out_free;
   logic                        send;
   logic                        pop;
   logic                        acc_empty;
   logic [RATIO-1:0]            keep;

   always_comb begin
      acc_empty = (cnt_q == '0);
      out_free  = !m_valid_q || m_ready;
      send      = out_free && ((cnt_q == FULL) || (flush_pend_q && !acc_empty));
      pop       = rrst_n && !rempty && !flush_pend_q && ((cnt_q != FULL) || send);

      keep = '0;
      for (int i = 0; i < RATIO; i++) begin
         keep[i] = (cnt_t'(i) < cnt_q);
      end

      acc_d = acc_q;
      cnt_d = cnt_q;
      if (send) begin
         acc_d = '0;
         cnt_d = '0;
      end
      // a pop that coincides with a send starts the next beat in lane 0
      if (pop) begin
         if (send) begin
            acc_d[0] = rdata;
            cnt_d    = cnt_t'(1);
         end else begin
            acc_d[cnt_q[LW-1:0]] = rdata;
            cnt_d                = cnt_q + cnt_t'(1);
         end
      end

      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;
      if (send) begin
         for (int i = 0; i < RATIO; i++) begin
            m_data_d[i] = keep[i] ? acc_q[i] : '0;
         end
         m_keep_d  = keep;
         m_last_d  = flush_pend_q;
         m_valid_d = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end

      // flushes arriving while one is pending are absorbed
      if (flush_pend_q) begin
         flush_pend_d = !(send || acc_empty);
      end else begin
         flush_pend_d = flush;
      end
      flush_done_d = flush_pend_q && (send || acc_empty);
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         m_data_q     <= '0;
         m_keep_q     <= '0;
         m_last_q     <= 1'b0;
         m_valid_q    <= 1'b0;
         flush_pend_q <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         m_data_q     <= m_data_d;
         m_keep_q     <= m_keep_d;
         m_last_q     <= m_last_d;
         m_valid_q    <= m_valid_d;
         flush_pend_q <= flush_pend_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign rinc       = pop;
   assign m_data     = m_data_q;
   assign m_keep     = m_keep_q;
   assign m_last     = m_last_q;
   assign m_valid    = m_valid_q;
   assign flush_done = flush_done_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: beat table, directed corner sequences and a
// random run against a queue-based model of the packing rules.
module tb_fifo_rd_packer;
   localparam int DSIZE = 8;
   localparam int RATIO = 4;
   localparam int W     = DSIZE * RATIO;

   typedef struct {
      int               n;
      bit               fl;
      logic [W-1:0]     d;
      logic [RATIO-1:0] k;
      bit               l;
   } vec_t;

   typedef struct {
      logic [W-1:0]     d;
      logic [RATIO-1:0] k;
      logic             l;
   } beat_t;

   logic             rclk = 1'b0;
   logic             rrst_n;
   logic [DSIZE-1:0] rdata;
   logic             rempty;
   logic             rinc;
   logic             flush;
   logic [W-1:0]     m_data;
   logic [RATIO-1:0] m_keep;
   logic             m_last;
   logic             m_valid;
   logic             m_ready;
   logic             flush_done;

   int errors = 0;
   int checks = 0;

   logic [DSIZE-1:0] fifo[$];
   beat_t            beats[$];
   logic             rinc_seen;

   // model state
   logic [DSIZE-1:0] macc[$];
   logic             mv, ml, mfp, mfd;
   logic [W-1:0]     md;
   logic [RATIO-1:0] mk;

   always #5 rclk = ~rclk;

   fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
      .rinc(rinc), .flush(flush), .m_data(m_data), .m_keep(m_keep),
      .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
      .flush_done(flush_done)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      macc.delete();
      mv  = 1'b0;
      ml  = 1'b0;
      mfp = 1'b0;
      mfd = 1'b0;
      md  = '0;
      mk  = '0;
   endtask

   task automatic cycle();
      bit               snd, mr, rst, nfd;
      int               sz;
      logic [DSIZE-1:0] w;
      rempty = (fifo.size() == 0);
      rdata  = rempty ? '0 : fifo[0];
      w      = rdata;
      #1;
      rinc_seen = rinc;
      rst       = !rrst_n;
      sz  = macc.size();
      snd = (!mv || m_ready) && (sz == RATIO || (mfp && sz > 0));
      mr  = !rempty && !mfp && (sz < RATIO || snd);
      if (rst) begin
         chk("rst_rinc", 64'(rinc), 64'(0));
         chk("rst_valid", 64'(m_valid), 64'(0));
         chk("rst_data", 64'(m_data), 64'(0));
         chk("rst_keep", 64'(m_keep), 64'(0));
         chk("rst_last", 64'(m_last), 64'(0));
         chk("rst_fdone", 64'(flush_done), 64'(0));
      end else begin
         chk("rinc", 64'(rinc), 64'(mr));
         chk("valid", 64'(m_valid), 64'(mv));
         chk("fdone", 64'(flush_done), 64'(mfd));
         if (mv) begin
            chk("data", 64'(m_data), 64'(md));
            chk("keep", 64'(m_keep), 64'(mk));
            chk("last", 64'(m_last), 64'(ml));
         end
      end
      if (!rst && m_valid && m_ready)
         beats.push_back('{m_data, m_keep, m_last});
      @(posedge rclk);
      if (rinc_seen && fifo.size() > 0) void'(fifo.pop_front());
      if (rst) begin
         model_reset();
      end else begin
         nfd = mfp && (snd || sz == 0);
         if (snd) begin
            md = '0;
            mk = '0;
            for (int i = 0; i < sz; i++) begin
               md[i*DSIZE +: DSIZE] = macc[i];
               mk[i] = 1'b1;
            end
            ml = mfp;
            mv = 1'b1;
            macc.delete();
         end else if (m_ready) begin
            mv = 1'b0;
         end
         if (mfp) begin
            if (snd || sz == 0) mfp = 1'b0;
         end else begin
            mfp = flush;
         end
         if (mr) macc.push_back(w);
         mfd = nfd;
      end
      @(negedge rclk);
   endtask

   task automatic do_reset();
      rrst_n  = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b0;
      fifo.delete();
      cycle();
      cycle();
      rrst_n = 1'b1;
      beats.delete();
   endtask

   task automatic push_word(input logic [31:0] v);
      fifo.push_back(v[DSIZE-1:0]);
   endtask

   vec_t vecs[5];

   initial begin
      int   npop;
      bit   found;
      vecs[0] = '{4, 1'b0, 32'h04030201, 4'hF, 1'b0};
      vecs[1] = '{2, 1'b1, 32'h0000A2A1, 4'h3, 1'b1};
      vecs[2] = '{1, 1'b1, 32'h000000B1, 4'h1, 1'b1};
      vecs[3] = '{3, 1'b1, 32'h00C3C2C1, 4'h7, 1'b1};
      vecs[4] = '{4, 1'b0, 32'hD4D3D2D1, 4'hF, 1'b0};

      rrst_n  = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b1;
      rempty  = 1'b1;
      rdata   = '0;
      model_reset();

      // reset held with a non-empty FIFO
      push_word(32'h55);
      cycle();
      cycle();
      chk("reset_hold_rinc", 64'(rinc_seen), 64'(0));
      chk("reset_hold_valid", 64'(m_valid), 64'(0));

      // table of single beats
      foreach (vecs[v]) begin
         do_reset();
         m_ready = 1'b1;
         for (int i = 0; i < vecs[v].n; i++)
            push_word(32'(vecs[v].d[i*DSIZE +: DSIZE]));
         for (int i = 0; i < vecs[v].n; i++) cycle();
         if (vecs[v].fl) begin
            flush = 1'b1;
            cycle();
            flush = 1'b0;
         end
         found = 1'b0;
         for (int k = 0; k < 8 && !found; k++) begin
            if (m_valid) found = 1'b1;
            else cycle();
         end
         chk("tbl_found", 64'(found), 64'(1));
         chk("tbl_data", 64'(m_data), 64'(vecs[v].d));
         chk("tbl_keep", 64'(m_keep), 64'(vecs[v].k));
         chk("tbl_last", 64'(m_last), 64'(vecs[v].l));
         chk("tbl_fdone", 64'(flush_done), 64'(vecs[v].fl));
      end

      // streaming
      do_reset();
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push_word(32'(i));
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("stream_rinc", 64'(rinc_seen), 64'(1));
      end
      for (int i = 0; i < 3; i++) cycle();
      chk("stream_nbeats", 64'(beats.size()), 64'(2));
      if (beats.size() >= 2) begin
         chk("stream_b0", 64'({beats[0].d, beats[0].k, beats[0].l}),
             64'({32'h04030201, 4'hF, 1'b0}));
         chk("stream_b1", 64'({beats[1].d, beats[1].k, beats[1].l}),
             64'({32'h08070605, 4'hF, 1'b0}));
      end

      // backpressure
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 12; i++) push_word(32'h21 + 32'(i));
      npop = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         npop += int'(rinc_seen);
         if (i == 6) chk("bp_hold_mid", 64'(m_data), 64'(32'h24232221));
      end
      chk("bp_pops", 64'(npop), 64'(8));
      chk("bp_rinc_low", 64'(rinc_seen), 64'(0));
      chk("bp_hold_end", 64'({m_valid, m_data}), 64'({1'b1, 32'h24232221}));
      m_ready = 1'b1;
      for (int i = 0; i < 12; i++) cycle();
      chk("bp_nbeats", 64'(beats.size()), 64'(3));
      if (beats.size() >= 3) begin
         chk("bp_b0", 64'(beats[0].d), 64'(32'h24232221));
         chk("bp_b1", 64'(beats[1].d), 64'(32'h28272625));
         chk("bp_b2", 64'(beats[2].d), 64'(32'h2C2B2A29));
      end

      // partial flush, rinc held off while pending
      do_reset();
      m_ready = 1'b1;
      push_word(32'hA1);
      push_word(32'hA2);
      cycle();
      cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      push_word(32'hEE);
      rempty = 1'b0;
      rdata  = 8'hEE;
      #1;
      chk("pend_rinc", 64'(rinc), 64'(0));
      cycle();
      chk("pf_beat", 64'({m_valid, m_data, m_keep, m_last}),
          64'({1'b1, 32'h0000A2A1, 4'h3, 1'b1}));
      chk("pf_fdone", 64'(flush_done), 64'(1));
      cycle();
      chk("pf_fdone_once", 64'(flush_done), 64'(0));

      // empty flush, second flush absorbed
      do_reset();
      m_ready = 1'b1;
      flush   = 1'b1;
      cycle();
      chk("ef_fdone0", 64'(flush_done), 64'(0));
      cycle();
      flush = 1'b0;
      chk("ef_fdone1", 64'({flush_done, m_valid}), 64'({1'b1, 1'b0}));
      cycle();
      chk("ef_fdone2", 64'(flush_done), 64'(0));
      cycle();
      chk("ef_fdone3", 64'({flush_done, m_valid}), 64'(0));

      // reset mid-beat
      do_reset();
      m_ready = 1'b1;
      push_word(32'hF1);
      push_word(32'hF2);
      push_word(32'hF3);
      for (int i = 0; i < 3; i++) cycle();
      rrst_n = 1'b0;
      cycle();
      chk("mid_rst_valid", 64'(m_valid), 64'(0));
      rrst_n = 1'b1;
      for (int i = 0; i < 4; i++) push_word(32'h11 + 32'(i));
      for (int i = 0; i < 7; i++) cycle();
      chk("mid_nbeats", 64'(beats.size()), 64'(1));
      if (beats.size() >= 1)
         chk("mid_beat", 64'({beats[0].d, beats[0].k}),
             64'({32'h14131211, 4'hF}));

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 15) == 0);
         rrst_n  = ($urandom_range(0, 399) != 0);
         if ($urandom_range(0, 2) != 0 && fifo.size() < 20)
            fifo.push_back(DSIZE'($urandom));
         cycle();
      end
      rrst_n = 1'b1;
      flush  = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
